// File: rtl/rr_grant_scheduler.sv
// Four-way round-robin grant scheduler with per-owner quantum limit.
// All outputs are registered; priority rotates to winner+1 on every new grant.
module rr_grant_scheduler #(
  parameter int N_REQ   = 4,
  parameter int QUANTUM = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             En,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_id,
  output logic             busy,
  output logic             q_expired
);

  localparam int HC_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(QUANTUM - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [HC_W-1:0]   hold_cnt, hold_nxt;
  logic [N_REQ-1:0]  grant_nxt, cand;
  logic [1:0]        id_nxt;
  logic              qexp_nxt;
  logic              owner_req, expire;
  logic [2:0]        sel;

  // Returns {found, index} of the first set bit searching from p upward, mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    owner_req = req[grant_id];
    expire    = (state == OWNED) && owner_req && (hold_cnt == HC_LAST);
    cand      = req;
    if (expire) cand[grant_id] = 1'b0;
    sel       = pick(cand, ptr);

    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    grant_nxt = grant;
    id_nxt    = grant_id;
    qexp_nxt  = 1'b0;

    if (!En) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      id_nxt    = 2'd0;
      hold_nxt  = '0;
    end else if ((state == OWNED) && owner_req && !expire) begin
      hold_nxt = hold_cnt + 1'b1;
    end else begin
      // New arbitration: from IDLE, after a release, or at quantum expiry.
      qexp_nxt = expire;
      hold_nxt = '0;
      if (sel[2]) begin
        state_nxt = OWNED;
        grant_nxt = N_REQ'(1) << sel[1:0];
        id_nxt    = sel[1:0];
        ptr_nxt   = sel[1:0] + 2'd1;
      end else if (expire) begin
        // Sole requester re-granted after expiry; grant and id stay put.
        state_nxt = OWNED;
        ptr_nxt   = grant_id + 2'd1;
      end else begin
        state_nxt = IDLE;
        grant_nxt = '0;
        id_nxt    = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_id  <= 2'd0;
      busy      <= 1'b0;
      q_expired <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      grant     <= grant_nxt;
      grant_id  <= id_nxt;
      busy      <= (state_nxt == OWNED);
      q_expired <= qexp_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios plus random traffic,
// compared every cycle against a behavioural round-robin model.
module tb_rr_grant_scheduler;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       En = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       q_expired;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owner (-1 none), cycles held so far, next priority, pulse.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_qexp  = 1'b0;

  rr_grant_scheduler #(.N_REQ(4), .QUANTUM(Q)) dut (
    .clk(clk), .reset_n(reset_n), .En(En), .req(req),
    .grant(grant), .grant_id(grant_id), .busy(busy), .q_expired(q_expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_qexp  = 1'b0;
  endtask

  task automatic model_edge(input bit en, input logic [3:0] r);
    bit         exp_now;
    int         w;
    logic [3:0] masked;
    m_qexp = 1'b0;
    if (!en) begin
      m_owner = -1;
      m_held  = 0;
    end else if (m_owner >= 0 && r[m_owner] && m_held < Q) begin
      m_held++;
    end else begin
      exp_now = (m_owner >= 0) && r[m_owner];
      masked  = r;
      if (exp_now) masked[m_owner] = 1'b0;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && masked[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
        m_ptr   = (w + 1) % 4;
      end else if (exp_now) begin
        m_held = 1;
      end else begin
        m_owner = -1;
      end
      m_qexp = exp_now;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check({tag, ".grant"}, grant, eg);
    check({tag, ".id"}, {2'b00, grant_id}, (m_owner < 0) ? 4'd0 : 4'(m_owner));
    check({tag, ".busy"}, {3'b000, busy}, {3'b000, m_owner >= 0});
    check({tag, ".qexp"}, {3'b000, q_expired}, {3'b000, m_qexp});
  endtask

  task automatic step(input string tag, input bit en, input logic [3:0] r);
    En  = en;
    req = r;
    @(posedge clk);
    model_edge(en, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rr;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    repeat (5) step("idle", 1'b1, 4'b0000);

    repeat (3) step("single2", 1'b1, 4'b0100);
    check("single2.direct", grant, 4'b0100);
    step("single2.drop", 1'b1, 4'b0000);
    check("single2.zero", grant, 4'b0000);
    step("ptr3", 1'b1, 4'b1111);
    check("ptr3.direct", grant, 4'b1000);
    step("release", 1'b1, 4'b0000);

    repeat (4 * Q + 2) step("all", 1'b1, 4'b1111);
    step("release", 1'b1, 4'b0000);

    step("h.own1", 1'b1, 4'b0010);
    repeat (2) step("h.hold", 1'b1, 4'b1011);
    step("h.drop", 1'b1, 4'b1001);
    check("handoff.direct", grant, 4'b1000);
    step("release", 1'b1, 4'b0000);

    repeat (20) step("solo0", 1'b1, 4'b0001);
    step("release", 1'b1, 4'b0000);

    repeat (3) step("en.pre", 1'b1, 4'b1111);
    step("en.off", 1'b0, 4'b1111);
    check("en.off.direct", grant, 4'b0000);
    repeat (2) step("en.on", 1'b1, 4'b1111);

    repeat (3) step("rst.pre", 1'b1, 4'b0110);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst.async");
    @(posedge clk);
    #1;
    check_all("rst.held");
    @(negedge clk);
    reset_n = 1'b1;
    step("rst.after", 1'b1, 4'b1111);
    check("rst.ptr0", grant, 4'b0001);

    rr = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 4) == 0) rr[b] = ~rr[b];
      step("rand", ($urandom_range(0, 15) != 0), rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Registered four-way round-robin grant scheduler for a single shared resource. It sits above the fixed-priority encoder in the arbiter path and rotates priority after every grant. It holds each grant while the owner keeps requesting, bounded by a quantum counter. It produces a stable one-hot grant plus encoded owner ID and status flags for the downstream datapath mux.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4, other values are unsupported.
- `QUANTUM`, 8: maximum consecutive cycles one grant is held; legal range 1..255.
- `clk`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `En`  in  1  scheduler enable; low forces release of any grant.
- `req`  in  4  level request per requester; bit i is requester i.
- `grant`  out  4  registered one-hot grant, or all-zero.
- `grant_id`  out  2  binary index of the current owner; 0 when `grant` is zero.
- `busy`  out  1  high when `grant` is nonzero.
- `q_expired`  out  1  one-cycle pulse on the cycle after the owner lost its grant by quantum expiry.

## Operation
- State machine:
  - IDLE: `grant` is 0.
  - OWNED: exactly one `grant` bit is high.
- Internal registers:
  - `ptr[1:0]`: highest-priority index.
  - `hold_cnt`: width clog2(QUANTUM), minimum 1 bit; counts cycles the current owner has held the grant, 0..QUANTUM-1.
- Winner selection (combinational, from current `req` and `ptr`):
  - Search order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, mod 4.
  - The first set bit wins.
- IDLE -> OWNED: at an edge with `En`=1 and `req`≠0.
  - Grant the winner and clear `hold_cnt`.
  - Set `ptr` = winner+1 (mod 4).
- OWNED, owner `req` still high, `hold_cnt` < QUANTUM-1, `En`=1: hold the grant and increment `hold_cnt`.
- OWNED, owner `req` low at the edge (release): zero-bubble handoff.
  - Grant the new winner from remaining requests, or go to IDLE if none.
  - `ptr` updates as on any new grant.
- OWNED, `hold_cnt` == QUANTUM-1 and owner `req` still high (expiry):
  - Select the winner from `req` with the owner's bit masked off.
  - If another requester wins, hand off to it.
  - If only the owner requests, re-grant the owner with `hold_cnt` cleared.
  - Either way, assert `q_expired` for one cycle.
- Owner release and expiry on the same edge: release wins, and `q_expired` stays low.
- `En`=0 at any edge:
  - `grant` goes to 0, the state goes to IDLE, and `hold_cnt` clears.
  - `ptr` is retained.
  - `q_expired` stays low.
- QUANTUM=1: every grant lasts exactly one cycle, and `q_expired` pulses after each grant whose owner was still requesting.
- A new request from a non-owner never preempts the current owner before release or expiry.

## Timing
- Reset values:
  - `grant`=0, `grant_id`=0, `busy`=0, `q_expired`=0.
  - `ptr`=0, `hold_cnt`=0, state IDLE.
- Asynchronous reset mid-grant clears everything immediately, with no pulse.
- Latency is 1 cycle: `req` visible before edge k produces `grant` after edge k.
- Handoff has no idle cycle between owners.
- All outputs are registered; there is no combinational path from `req` or `En` to any output.
- Maximum wait for a persistently requesting input is 3×QUANTUM cycles after its request is first seen.
- `grant_id` and `busy` always update on the same edge as `grant`.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles, `En`=1 -> `grant`=0, `grant_id`=0, `busy`=0, `q_expired`=0 throughout.
- `req`=4'b0100 held for 3 cycles, then dropped:
  - `grant`=4'b0100 from edge 1 to edge 3, `grant_id`=2.
  - `grant` returns to 0 one cycle after `req` drops.
  - Next `ptr`=3.
- `req`=4'b1111 held, QUANTUM=8 -> `grant` sequence is 0001, 0010, 0100, 1000, 0001, each held 8 cycles, with a `q_expired` pulse at every transition.
- Owner 1 drops `req` while `req`=4'b1011 elsewhere -> on the next edge `grant`=4'b1000 with no zero cycle.
- Only `req`[0] held for 20 cycles, QUANTUM=8:
  - `grant` stays 0001 continuously.
  - `q_expired` pulses twice, after cycles 8 and 16.
- Mid-grant cases:
  - `En` drops mid-grant -> `grant`=0 on the next edge, with `ptr` retained.
  - `reset_n` pulsed low mid-grant -> all outputs read 0 before the next clock edge.
  - After `reset_n` releases, the next grant is decided from `ptr`=0.
